// File: rtl/mem_wb_stage24.sv
// Memory/writeback stage: issues one data-memory request per LOAD/STORE, waits for the ack,
// and emits a single-cycle register-file write strobe for ALU results and completed loads.
module mem_wb_stage24 #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  ex_kind,
  input  logic [23:0] ex_y,
  input  logic [23:0] ex_sdata,
  input  logic [3:0]  ex_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [23:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [23:0] mem_rdata,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [23:0] wb_data,
  output logic        mem_err
);

  typedef enum logic [1:0] {StIdle, StMem, StWb} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_load_q, is_load_d;
  logic        mem_req_d, mem_we_d, wb_valid_d, mem_err_d;
  logic [23:0] mem_addr_d, mem_wdata_d, wb_data_d;
  logic [3:0]  wb_rd_d;

  assign ex_ready = (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_load_d   = is_load_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd;
    wb_data_d   = wb_data;
    mem_err_d   = mem_err;

    case (state_q)
      StIdle: begin
        if (ex_valid) begin
          unique case (ex_kind)
            2'b00: begin
              wb_rd_d    = ex_rd;
              wb_data_d  = ex_y;
              wb_valid_d = (ex_rd != 4'd0);
              state_d    = StWb;
            end
            2'b01, 2'b10: begin
              mem_req_d   = 1'b1;
              mem_we_d    = ex_kind[1];
              mem_addr_d  = ex_y;
              mem_wdata_d = ex_sdata;
              cnt_d       = 8'd0;
              is_load_d   = ~ex_kind[1];
              if (!ex_kind[1]) wb_rd_d = ex_rd;
              state_d     = StMem;
            end
            default: ;  // BEQ/NOP: consumed with no side effects
          endcase
        end
      end
      StMem: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (is_load_q) begin
            wb_data_d  = mem_rdata;
            wb_valid_d = (wb_rd != 4'd0);
            state_d    = StWb;
          end else begin
            state_d = StIdle;
          end
        end else if (cnt_q == TIMEOUT) begin
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      is_load_q <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 24'd0;
      mem_wdata <= 24'd0;
      wb_valid  <= 1'b0;
      wb_rd     <= 4'd0;
      wb_data   <= 24'd0;
      mem_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_load_q <= is_load_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      wb_valid  <= wb_valid_d;
      wb_rd     <= wb_rd_d;
      wb_data   <= wb_data_d;
      mem_err   <= mem_err_d;
    end
  end

endmodule

// File: doc/mem_wb_stage24.md
MEM_WB_STAGE24 -- requirements
Module: mem_wb_stage24

Interface
REQ-001 Parameter: TIMEOUT, default 8'd255; MEM-state cycles without mem_ack before abort.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ex_valid  in  1  execute stage presents an instruction result.
REQ-006 ex_ready  out  1  stage can accept; high exactly when FSM is in IDLE.
REQ-007 ex_kind  in  2  00 ALU writeback, 01 LOAD, 10 STORE, 11 no-writeback (BEQ/NOP).
REQ-008 ex_y  in  24  24-bit ALU result: writeback value, or word address for LOAD/STORE.
REQ-009 ex_sdata  in  24  store data (rt register value).
REQ-010 ex_rd  in  4  destination register index.
REQ-011 mem_req  out  1  data-memory request, registered.
REQ-012 mem_we  out  1  1 = write (STORE), 0 = read (LOAD), registered.
REQ-013 mem_addr  out  24  request address, registered.
REQ-014 mem_wdata  out  24  store data, registered.
REQ-015 mem_ack  in  1  memory completion; read data valid in the same cycle.
REQ-016 mem_rdata  in  24  load data.
REQ-017 wb_valid  out  1  one-cycle register-file write strobe, registered.
REQ-018 wb_rd  out  4  writeback register index.
REQ-019 wb_data  out  24  writeback data.
REQ-020 mem_err  out  1  sticky timeout flag.

Function
REQ-021 The FSM SHALL have states IDLE, MEM and WB.
REQ-022 Transfer SHALL occur when ex_valid && ex_ready; ex_* inputs are sampled only on transfer.
REQ-023 IDLE, kind 00: capture ex_y and ex_rd, go to WB; wb_valid high the next cycle (latency 1).
REQ-024 IDLE, kind 01/10: next cycle mem_req=1, mem_addr=ex_y, mem_we=(kind==10), mem_wdata=ex_sdata, wait counter=0, go to MEM.
REQ-025 IDLE, kind 11: instruction consumed, stay IDLE, no memory or writeback activity.
REQ-026 MEM: mem_req, mem_we, mem_addr and mem_wdata SHALL hold stable until the ack edge.
REQ-027 MEM with mem_ack on a LOAD: capture mem_rdata into wb_data, clear mem_req, go to WB.
REQ-028 MEM with mem_ack on a STORE: clear mem_req, go to IDLE, no writeback.
REQ-029 mem_ack in the first MEM cycle SHALL be honoured (zero-wait memory).
REQ-030 MEM without mem_ack: increment wait counter (8-bit).
REQ-031 If the counter equals TIMEOUT and mem_ack is low, SHALL clear mem_req, set mem_err, and go to IDLE without writeback.
REQ-032 WB: wb_valid SHALL be high for exactly one cycle, then the FSM returns to IDLE.
REQ-033 wb_valid SHALL be suppressed when wb_rd==0 (R0 hardwired zero); the FSM still passes through WB.
REQ-034 mem_ack outside MEM SHALL be ignored.
REQ-035 ex_ready SHALL be low in MEM and WB; ex_valid is ignored there.
REQ-036 Latencies: ALU transfer T -> wb_valid T+1; LOAD transfer T, ack T+1 -> wb_valid T+2; STORE transfer T, ack T+1 -> ex_ready T+2.
REQ-037 All data paths SHALL be 24 bits with no sign extension or truncation.

Reset
REQ-038 On rst, outputs and state SHALL take reset values at the next edge: FSM IDLE; mem_req, mem_we, wb_valid, mem_err = 0; mem_addr, mem_wdata, wb_data = 0; wb_rd = 0; counter = 0.
REQ-039 rst in MEM SHALL abandon the transaction: mem_req is 0 after the edge, and a later mem_ack produces no writeback.
REQ-040 rst SHALL take priority over all simultaneous events, including ex_valid and mem_ack in the same cycle.
REQ-041 mem_err SHALL clear only on rst.

Verification
REQ-042 ALU: kind 00, ex_y=24'h00ABCD, rd=3 -> next cycle wb_valid=1, wb_rd=3, wb_data=24'h00ABCD; ex_ready high one cycle later.
REQ-043 LOAD: kind 01, ex_y=24'h000100, ack 3 cycles after req with rdata=24'hFFFFFE -> mem_addr stable at 24'h000100 while waiting; one-cycle wb_valid with data 24'hFFFFFE.
REQ-044 STORE: kind 10, ex_y=24'h000010, sdata=24'h123456, zero-wait ack -> mem_we=1 for one req cycle, no wb_valid, ex_ready back at T+2.
REQ-045 Timeout: LOAD with ack never asserted -> mem_req drops after 256 MEM cycles; mem_err=1 and stays 1; no wb_valid.
REQ-046 Reset mid-MEM: rst during a LOAD wait, then ack -> mem_req=0 after the reset edge, no wb_valid, all outputs 0.
REQ-047 R0 and kind 11: ALU result to rd=0 or kind 11 -> no wb_valid, and the next transfer is accepted normally.
